// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states
// and the datapath mux/ALU select values.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_AUIPC, S_EX_ADR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_WB_ALU, S_WB_LUI, S_EX_BR,
    S_JAL1, S_JAL2, S_JAL3, S_JALR1, S_JALR2,
    S_MD_START, S_MD_WAIT, S_WB_MD, S_TRAP
  } state_t;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BR     = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired flags the wait cycle that
// reaches MEM_TIMEOUT. MEM_TIMEOUT=0 never expires.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)                    cnt <= '0;
    else if (en && (MEM_TIMEOUT > 0))  cnt <= cnt + CW'(1);
  end

  // The wait cycle that would bring the count to the limit is the expiring one.
  assign expired = (MEM_TIMEOUT > 0) && en && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl_ws.sv
// Main controller for the multicycle RV32I datapath with memory wait states,
// optional mul/div sequencing, AUIPC and a sticky trap state.
module multicycle_ctrl_ws
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit MULDIV_EN       = 1'b1,
  parameter bit AUIPC_EN        = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       md_done,
  output logic       mem_req,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       branch,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] immSrc,
  output logic       md_start,
  output logic       md_sel,
  output logic       trap
);

  localparam state_t ILL_NXT = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

  state_t state, nxt;
  logic   in_mem, waiting, clr, expired;

  assign in_mem  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign waiting = in_mem && !mem_ready;
  assign clr     = (nxt != state) &&
                   ((nxt == S_FETCH) || (nxt == S_MEM_RD) || (nxt == S_MEM_WR));

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clr(clr), .en(waiting), .expired(expired)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) nxt = S_DECODE; else if (expired) nxt = S_TRAP;
      S_DECODE: begin
        case (op)
          OP_R:      nxt = (MULDIV_EN && funct7 == F7_MULDIV) ? S_MD_START : S_EX_R;
          OP_I:      nxt = S_EX_I;
          OP_LOAD,
          OP_STORE:  nxt = S_EX_ADR;
          OP_BRANCH: nxt = S_EX_BR;
          OP_JAL:    nxt = S_JAL1;
          OP_JALR:   nxt = S_JALR1;
          OP_LUI:    nxt = S_WB_LUI;
          OP_AUIPC:  nxt = AUIPC_EN ? S_EX_AUIPC : ILL_NXT;
          default:   nxt = ILL_NXT;
        endcase
      end
      S_EX_R, S_EX_I, S_EX_AUIPC: nxt = S_WB_ALU;
      S_EX_ADR:   nxt = (op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) nxt = S_WB_MEM; else if (expired) nxt = S_TRAP;
      S_MEM_WR:   if (mem_ready) nxt = S_FETCH;  else if (expired) nxt = S_TRAP;
      S_JAL1:     nxt = S_JAL2;
      S_JAL2:     nxt = S_JAL3;
      S_JALR1:    nxt = S_JALR2;
      S_JALR2:    nxt = S_WB_ALU;
      // md_done during MD_START belongs to no request and is dropped.
      S_MD_START: nxt = S_MD_WAIT;
      S_MD_WAIT:  if (md_done) nxt = S_WB_MD;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nxt;
  end

  always_comb begin
    mem_req = 1'b0; adrSrc = 1'b0; memWrite = 1'b0; IRWrite = 1'b0;
    PCUpdate = 1'b0; branch = 1'b0; regWrite = 1'b0; md_start = 1'b0;
    md_sel = 1'b0; trap = 1'b0;
    resultSrc = RES_ALUOUT; ALUSrcA = SRCA_PC; ALUSrcB = SRCB_RS2;
    ALUOp = ALU_ADD; immSrc = IMM_I;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1; ALUSrcB = SRCB_FOUR; resultSrc = RES_ALU;
          IRWrite = mem_ready; PCUpdate = mem_ready;
        end
        S_DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; immSrc = IMM_B; end
        S_EX_R:     begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUOp = ALU_RFUNCT; end
        S_EX_I:     begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUOp = ALU_IFUNCT; end
        S_EX_AUIPC: begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; immSrc = IMM_U; end
        S_EX_ADR: begin
          ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM;
          immSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEM_RD:   begin mem_req = 1'b1; adrSrc = 1'b1; end
        S_MEM_WR:   begin mem_req = 1'b1; adrSrc = 1'b1; memWrite = 1'b1; end
        S_WB_MEM:   begin resultSrc = RES_DATA; regWrite = 1'b1; end
        S_WB_ALU:   begin resultSrc = RES_ALUOUT; regWrite = 1'b1; end
        S_WB_LUI:   begin resultSrc = RES_IMM; immSrc = IMM_U; regWrite = 1'b1; end
        S_EX_BR: begin
          ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUOp = ALU_BR; branch = 1'b1;
        end
        S_JAL1:     begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; end
        S_JAL2: begin
          regWrite = 1'b1; resultSrc = RES_ALUOUT;
          ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; immSrc = IMM_J;
        end
        S_JAL3:     begin PCUpdate = 1'b1; resultSrc = RES_ALUOUT; end
        S_JALR1:    begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; immSrc = IMM_I; end
        S_JALR2: begin
          PCUpdate = 1'b1; resultSrc = RES_ALUOUT;
          ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR;
        end
        S_MD_START: md_start = 1'b1;
        S_WB_MD:    begin md_sel = 1'b1; regWrite = 1'b1; end
        S_TRAP:     trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_ws.sv
// Scoreboarded directed bench: each queued entry carries one cycle of stimulus
// and the expected controller outputs for two differently parameterised DUTs.
module tb_multicycle_ctrl_ws;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011,
                         ST_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111,
                         JALR_OP = 7'b1100111, LUI_OP = 7'b0110111, AUIPC_OP = 7'b0010111,
                         BAD_OP = 7'b1111111, MD_F7 = 7'b0000001;

  typedef enum {RST, FETCH, DECODE, EX_R, EX_I, EX_AUIPC, EX_ADR_L, EX_ADR_S, MEM_RD,
                MEM_WR, WB_MEM, WB_ALU, WB_LUI, EX_BR, JAL1, JAL2, JAL3, JALR1, JALR2,
                MD_START, MD_WAIT, WB_MD, TRAP} ts_t;

  typedef struct packed {
    logic       mem_req, adrSrc, memWrite, IRWrite, PCUpdate, branch, regWrite;
    logic [1:0] resultSrc, srcA, srcB, aluop;
    logic [2:0] imm;
    logic       md_start, md_sel, trap;
  } ovec_t;

  typedef struct {
    string      tag;
    bit         sel_b;
    logic       r, rdy, done;
    logic [6:0] op, f7;
    ovec_t      exp;
  } ent_t;

  logic clk = 1'b0;
  logic rst, mem_ready, md_done;
  logic [6:0] op, funct7;

  logic       a_req, a_adr, a_mw, a_irw, a_pcu, a_br, a_rw, a_mds, a_mdsel, a_trap;
  logic [1:0] a_res, a_sa, a_sb, a_aop;
  logic [2:0] a_imm;
  logic       b_req, b_adr, b_mw, b_irw, b_pcu, b_br, b_rw, b_mds, b_mdsel, b_trap;
  logic [1:0] b_res, b_sa, b_sb, b_aop;
  logic [2:0] b_imm;
  ovec_t oa, ob;

  assign oa = {a_req, a_adr, a_mw, a_irw, a_pcu, a_br, a_rw, a_res, a_sa, a_sb, a_aop,
               a_imm, a_mds, a_mdsel, a_trap};
  assign ob = {b_req, b_adr, b_mw, b_irw, b_pcu, b_br, b_rw, b_res, b_sa, b_sb, b_aop,
               b_imm, b_mds, b_mdsel, b_trap};

  always #5 clk = ~clk;

  multicycle_ctrl_ws #(.MEM_TIMEOUT(4), .MULDIV_EN(1'b1), .AUIPC_EN(1'b1),
                       .TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .op(op), .funct7(funct7), .mem_ready(mem_ready),
    .md_done(md_done), .mem_req(a_req), .adrSrc(a_adr), .memWrite(a_mw),
    .IRWrite(a_irw), .PCUpdate(a_pcu), .branch(a_br), .regWrite(a_rw),
    .resultSrc(a_res), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_aop),
    .immSrc(a_imm), .md_start(a_mds), .md_sel(a_mdsel), .trap(a_trap));

  multicycle_ctrl_ws #(.MEM_TIMEOUT(0), .MULDIV_EN(1'b0), .AUIPC_EN(1'b0),
                       .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .op(op), .funct7(funct7), .mem_ready(mem_ready),
    .md_done(md_done), .mem_req(b_req), .adrSrc(b_adr), .memWrite(b_mw),
    .IRWrite(b_irw), .PCUpdate(b_pcu), .branch(b_br), .regWrite(b_rw),
    .resultSrc(b_res), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_aop),
    .immSrc(b_imm), .md_start(b_mds), .md_sel(b_mdsel), .trap(b_trap));

  ent_t       sbq[$];
  int         ncmp = 0, nfail = 0;
  string      cur_nm;
  logic [6:0] cur_op, cur_f7;
  bit         cur_b;

  // Expected outputs per controller state, taken from the state table.
  function automatic ovec_t ev(ts_t s, logic rdy);
    ovec_t v;
    v = '0;
    case (s)
      FETCH:    begin v.mem_req = 1; v.srcB = 2'b10; v.resultSrc = 2'b10;
                      v.IRWrite = rdy; v.PCUpdate = rdy; end
      DECODE:   begin v.srcA = 2'b01; v.srcB = 2'b01; v.imm = 3'b010; end
      EX_R:     begin v.srcA = 2'b10; v.aluop = 2'b10; end
      EX_I:     begin v.srcA = 2'b10; v.srcB = 2'b01; v.aluop = 2'b11; end
      EX_AUIPC: begin v.srcA = 2'b01; v.srcB = 2'b01; v.imm = 3'b100; end
      EX_ADR_L: begin v.srcA = 2'b10; v.srcB = 2'b01; end
      EX_ADR_S: begin v.srcA = 2'b10; v.srcB = 2'b01; v.imm = 3'b001; end
      MEM_RD:   begin v.mem_req = 1; v.adrSrc = 1; end
      MEM_WR:   begin v.mem_req = 1; v.adrSrc = 1; v.memWrite = 1; end
      WB_MEM:   begin v.resultSrc = 2'b01; v.regWrite = 1; end
      WB_ALU:   v.regWrite = 1;
      WB_LUI:   begin v.resultSrc = 2'b11; v.imm = 3'b100; v.regWrite = 1; end
      EX_BR:    begin v.srcA = 2'b10; v.aluop = 2'b01; v.branch = 1; end
      JAL1:     begin v.srcA = 2'b01; v.srcB = 2'b10; end
      JAL2:     begin v.regWrite = 1; v.srcA = 2'b01; v.srcB = 2'b01; v.imm = 3'b011; end
      JAL3:     v.PCUpdate = 1;
      JALR1:    begin v.srcA = 2'b10; v.srcB = 2'b01; end
      JALR2:    begin v.PCUpdate = 1; v.srcA = 2'b01; v.srcB = 2'b10; end
      MD_START: v.md_start = 1;
      WB_MD:    begin v.md_sel = 1; v.regWrite = 1; end
      TRAP:     v.trap = 1;
      default:  ;
    endcase
    return v;
  endfunction

  task automatic instr(string nm, logic [6:0] o, logic [6:0] f7, bit selb);
    cur_nm = nm; cur_op = o; cur_f7 = f7; cur_b = selb;
  endtask

  task automatic push(ts_t s, logic rdy = 1'b1, logic done = 1'b0);
    ent_t e;
    e.tag = $sformatf("%s/%s", cur_nm, s.name());
    e.sel_b = cur_b; e.r = (s == RST); e.rdy = rdy; e.done = done;
    e.op = cur_op; e.f7 = cur_f7; e.exp = ev(s, rdy);
    sbq.push_back(e);
  endtask

  task automatic drain();
    ent_t  e;
    ovec_t obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      rst = e.r; mem_ready = e.rdy; md_done = e.done; op = e.op; funct7 = e.f7;
      #2;
      obs = e.sel_b ? ob : oa;
      ncmp++;
      assert (obs === e.exp) else begin
        nfail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; md_done = 1'b0; op = '0; funct7 = '0;

    instr("reset", R_OP, 7'd0, 0); push(RST); push(RST, 1'b0);
    instr("add", R_OP, 7'd0, 0);
    push(FETCH); push(DECODE); push(EX_R); push(WB_ALU);
    instr("lw", LD_OP, 7'd0, 0);
    push(FETCH); push(DECODE, 1'b0); push(EX_ADR_L);
    for (int i = 0; i < 3; i++) push(MEM_RD, 1'b0);
    push(MEM_RD); push(WB_MEM);
    instr("sw", ST_OP, 7'd0, 0);
    push(FETCH); push(DECODE); push(EX_ADR_S); push(MEM_WR, 1'b0); push(MEM_WR);
    instr("addi", I_OP, 7'd0, 0);
    push(FETCH); push(DECODE); push(EX_I); push(WB_ALU);
    instr("lui", LUI_OP, 7'd0, 0);
    push(FETCH); push(DECODE); push(WB_LUI);
    instr("auipc", AUIPC_OP, 7'd0, 0);
    push(FETCH); push(DECODE); push(EX_AUIPC); push(WB_ALU);
    instr("beq", BR_OP, 7'd0, 0);
    push(FETCH); push(DECODE); push(EX_BR);
    instr("mul", R_OP, MD_F7, 0);
    push(FETCH); push(DECODE); push(MD_START, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(MD_WAIT, 1'(i % 2));
    push(MD_WAIT, 1'b0, 1'b1); push(WB_MD);
    instr("jal", JAL_OP, 7'd0, 0);
    push(FETCH); push(DECODE); push(JAL1); push(JAL2); push(JAL3);
    instr("jalr", JALR_OP, 7'd0, 0);
    push(FETCH); push(DECODE); push(JALR1); push(JALR2); push(WB_ALU);
    instr("fetch_late", R_OP, 7'd0, 0);
    for (int i = 0; i < 3; i++) push(FETCH, 1'b0);
    push(FETCH); push(DECODE); push(EX_R); push(WB_ALU);
    instr("fetch_timeout", R_OP, 7'd0, 0);
    for (int i = 0; i < 4; i++) push(FETCH, 1'b0);
    push(TRAP); push(TRAP, 1'b0); push(TRAP); push(RST);
    instr("illegal", BAD_OP, 7'd0, 0);
    push(FETCH); push(DECODE); push(TRAP); push(TRAP); push(RST);
    instr("lw_timeout", LD_OP, 7'd0, 0);
    push(FETCH, 1'b0); push(FETCH, 1'b0); push(FETCH); push(DECODE); push(EX_ADR_L);
    for (int i = 0; i < 4; i++) push(MEM_RD, 1'b0);
    push(TRAP); push(RST);
    instr("mul_reset", R_OP, MD_F7, 0);
    push(FETCH); push(DECODE); push(MD_START); push(MD_WAIT); push(RST); push(FETCH, 1'b0);

    instr("b_reset", R_OP, 7'd0, 1); push(RST);
    instr("b_illegal", BAD_OP, 7'd0, 1);
    push(FETCH); push(DECODE); push(FETCH, 1'b0);
    instr("b_mul", R_OP, MD_F7, 1);
    push(FETCH); push(DECODE); push(EX_R); push(WB_ALU);
    instr("b_auipc", AUIPC_OP, 7'd0, 1);
    push(FETCH); push(DECODE);
    instr("b_no_timeout", R_OP, 7'd0, 1);
    for (int i = 0; i < 20; i++) push(FETCH, 1'b0);
    push(FETCH); push(DECODE); push(EX_R); push(WB_ALU); push(FETCH, 1'b0);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_ws.md
Name: multicycle_ctrl_ws

Overview:
Second-generation main controller for the multicycle RV32I datapath. It adds three things to the current controller:
- memory wait states through a req/ready handshake, with an optional timeout;
- an optional multi-cycle mul/div path (M-extension R-type);
- AUIPC support, plus a sticky trap on an illegal opcode or a memory timeout.

It drives the existing datapath mux and enable controls, using the same encodings.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on mem_ready before trap; 0 disables the timeout.
MULDIV_EN, 1, when 1, R-type with funct7=0000001 goes through the mul/div unit.
AUIPC_EN, 1, when 1, opcode 0010111 is legal.
TRAP_ON_ILLEGAL, 1, when 1, an illegal opcode enters TRAP; when 0, it returns to FETCH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
op  in  7  IR opcode
funct7  in  7  IR[31:25]
mem_ready  in  1  memory completed the access this cycle
md_done  in  1  mul/div result valid (single-cycle pulse)
mem_req  out  1  memory access request
adrSrc  out  1  0=PC, 1=ALUOut
memWrite  out  1  store strobe
IRWrite  out  1  latch instruction
PCUpdate  out  1  unconditional PC write
branch  out  1  conditional PC write (datapath ANDs with zero)
regWrite  out  1  register file write
resultSrc  out  2  00 ALUOut, 01 data, 10 ALU result, 11 imm
ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
ALUOp  out  2  00 add, 01 branch compare, 10 R funct, 11 I funct
immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
md_start  out  1  start mul/div
md_sel  out  1  select mul/div result onto result bus
trap  out  1  sticky halt indicator

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state is FETCH, the timeout counter is 0 and trap is 0. While rst=1, every output is 0.
- Outputs are decoded from the state. Every output not listed for a state is 0.
- In FETCH, IRWrite and PCUpdate are qualified by mem_ready; these are the only Mealy terms.

States and transitions:
- FETCH: mem_req=1, adrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, resultSrc=10. IRWrite=PCUpdate=mem_ready. Goes to DECODE on mem_ready; otherwise stays.
- DECODE: ALUSrcA=01, ALUSrcB=01, immSrc=010. Next state by opcode:
  - R-type: MD_START if MULDIV_EN and funct7=0000001; otherwise EX_R.
  - I-type: EX_I.
  - Load or store: EX_ADR.
  - Branch: EX_BR.
  - JAL: JAL1.
  - JALR: JALR1.
  - LUI: WB_LUI.
  - AUIPC: EX_AUIPC if AUIPC_EN.
  - Any other opcode: TRAP or FETCH, per TRAP_ON_ILLEGAL.
- EX_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to WB_ALU.
- EX_I: ALUSrcA=10, ALUSrcB=01, immSrc=000, ALUOp=11. Goes to WB_ALU.
- EX_AUIPC: ALUSrcA=01, ALUSrcB=01, immSrc=100. Goes to WB_ALU.
- EX_ADR: ALUSrcA=10, ALUSrcB=01, immSrc = 001 for a store, 000 for a load. Goes to MEM_WR for a store, MEM_RD for a load.
- MEM_RD: mem_req=1, adrSrc=1. Goes to WB_MEM on mem_ready.
- MEM_WR: mem_req=1, adrSrc=1, memWrite=1. Goes to FETCH on mem_ready.
- WB_MEM: resultSrc=01, regWrite=1. Goes to FETCH.
- WB_ALU: resultSrc=00, regWrite=1. Goes to FETCH.
- WB_LUI: resultSrc=11, immSrc=100, regWrite=1. Goes to FETCH.
- EX_BR: ALUSrcA=10, ALUSrcB=00, ALUOp=01, branch=1. Goes to FETCH.
- Jump sequences:
  - JAL: JAL1 (oldPC+4), then JAL2 (regWrite from ALUOut; ALU computes oldPC+immJ), then JAL3 (PCUpdate, resultSrc=00), then FETCH.
  - JALR: JALR1 (rs1+immI), then JALR2 (PCUpdate, resultSrc=00; ALU computes oldPC+4), then WB_ALU.
- Mul/div sequence:
  - MD_START: md_start=1 for exactly one cycle. Goes to MD_WAIT.
  - MD_WAIT: stays until md_done, then goes to WB_MD.
  - md_done arriving in the MD_START cycle is ignored.
  - WB_MD: md_sel=1, regWrite=1. Goes to FETCH.
- TRAP: all outputs 0 except trap=1. Exits only on rst.

Memory handshake:
- While waiting (mem_req=1, mem_ready=0), every output holds its value.
- mem_ready is ignored in states where mem_req=0.

Timeout:
- The counter clears on entry to FETCH, MEM_RD or MEM_WR.
- It increments each waiting cycle.
- If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP.
- mem_ready in the same cycle as the limit wins: the access completes and there is no trap.
- Counter width is clog2(MEM_TIMEOUT+1).

Reset mid-operation: rst in any state returns to FETCH on the next edge, with trap and the counter cleared.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - the opcode constants (including AUIPC 0010111);
  - the funct7 MULDIV constant;
  - the state enum (5 bits);
  - localparams for every resultSrc, ALUSrcA, ALUSrcB, ALUOp and immSrc encoding.
- One sub-module, mem_wait_timer: clear, count-enable and expired output, parametrised by MEM_TIMEOUT.

Test Plan:
- add with mem_ready=1 every cycle -> FETCH, DECODE, EX_R, WB_ALU, FETCH (4 cycles); regWrite=1 with resultSrc=00 in cycle 4.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_req=1 and adrSrc=1 held for 4 cycles; WB_MEM has resultSrc=01, regWrite=1; IRWrite never pulses outside FETCH.
- MEM_TIMEOUT=4, fetch with mem_ready=0 forever -> trap=1 after 4 wait cycles; trap stays 1 until rst; rst drives all outputs 0, then FETCH.
- mul (funct7=0000001) with md_done after 5 cycles -> md_start pulses once; WB_MD has md_sel=1, regWrite=1. With MULDIV_EN=0 the same instruction goes through EX_R instead.
- op=1111111: TRAP_ON_ILLEGAL=1 -> trap=1; TRAP_ON_ILLEGAL=0 -> FETCH with no writes.
- jal then jalr with ready=1 -> jal: regWrite at JAL2, PCUpdate at JAL3. jalr: PCUpdate at JALR2, regWrite at WB_ALU.
